// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pins plus decoded key events shared by the scanner, the keypad and the vending FSM.
// The scanner connects through the slave modport; its environment uses master.
interface keypad_scan_ctrl_if;
    logic       scan_en;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output scan_en,
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  scan_en,
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks the columns, debounces one latched key
// and reports it as a single-cycle event followed by a held level.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scan_ctrl_if.slave kp
);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } state_e;

    localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_TARGET = 4'(DEBOUNCE);

    state_e      state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [1:0]  row_q, row_d;
    logic [15:0] tickCnt_q, tickCnt_d;
    logic [3:0]  dbCnt_q, dbCnt_d;
    logic [3:0]  keyCode_q, keyCode_d;
    logic        keyValid_q, keyValid_d;
    logic        keyHeld_q, keyHeld_d;
    logic        en_q, en_d;
    logic [3:0]  sync1_q, rs_q;

    logic        tick;
    logic        latchedLow;
    logic [1:0]  lowRow;

    // en_q gates the divider so a re-enable always gets a full first dwell
    assign tick       = en_q && (tickCnt_q == TICK_LAST);
    assign latchedLow = ~rs_q[row_q];

    always_comb begin
        lowRow = 2'd3;
        if (!rs_q[2]) lowRow = 2'd2;
        if (!rs_q[1]) lowRow = 2'd1;
        if (!rs_q[0]) lowRow = 2'd0;
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        dbCnt_d    = dbCnt_q;
        keyCode_d  = keyCode_q;
        keyValid_d = 1'b0;
        keyHeld_d  = keyHeld_q;
        en_d       = kp.scan_en;
        tickCnt_d  = (!en_q || tick) ? 16'd0 : tickCnt_q + 16'd1;

        if (!kp.scan_en) begin
            state_d   = S_SCAN;
            col_d     = 2'd0;
            dbCnt_d   = 4'd0;
            keyHeld_d = 1'b0;
            tickCnt_d = 16'd0;
        end else if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (rs_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d = lowRow;
                        if (DB_TARGET == 4'd1) begin
                            keyCode_d  = {col_q, lowRow};
                            keyValid_d = 1'b1;
                            keyHeld_d  = 1'b1;
                            dbCnt_d    = 4'd0;
                            state_d    = S_HELD;
                        end else begin
                            dbCnt_d = 4'd1;
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (latchedLow) begin
                        if (dbCnt_q + 4'd1 == DB_TARGET) begin
                            keyCode_d  = {col_q, row_q};
                            keyValid_d = 1'b1;
                            keyHeld_d  = 1'b1;
                            dbCnt_d    = 4'd0;
                            state_d    = S_HELD;
                        end else begin
                            dbCnt_d = dbCnt_q + 4'd1;
                        end
                    end else begin
                        dbCnt_d = 4'd0;
                        col_d   = col_q + 2'd1;
                        state_d = S_SCAN;
                    end
                end
                S_HELD: begin
                    // a single low sample restarts the release count
                    if (!latchedLow) begin
                        if (dbCnt_q + 4'd1 == DB_TARGET) begin
                            keyHeld_d = 1'b0;
                            dbCnt_d   = 4'd0;
                            col_d     = col_q + 2'd1;
                            state_d   = S_SCAN;
                        end else begin
                            dbCnt_d = dbCnt_q + 4'd1;
                        end
                    end else begin
                        dbCnt_d = 4'd0;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_SCAN;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
            tickCnt_q  <= 16'd0;
            dbCnt_q    <= 4'd0;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
            keyHeld_q  <= 1'b0;
            en_q       <= 1'b1;
            sync1_q    <= 4'hF;
            rs_q       <= 4'hF;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tickCnt_q  <= tickCnt_d;
            dbCnt_q    <= dbCnt_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
            keyHeld_q  <= keyHeld_d;
            en_q       <= en_d;
            sync1_q    <= kp.row_n;
            rs_q       <= sync1_q;
        end
    end

    assign kp.col_n     = en_q ? ~(4'b0001 << col_q) : 4'hF;
    assign kp.key_code  = keyCode_q;
    assign kp.key_valid = keyValid_q;
    assign kp.key_held  = keyHeld_q;

endmodule
